// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port bundle between the access sequencer and the memory.
// Latency: n/a (wires only); the sequencer registers every request field.
// Backpressure: the memory holds off completion by keeping dm_ack low.
//
// Ports (as seen from the master/sequencer side):
//   dm_req   out  request valid, held until dm_ack or abandonment
//   dm_we    out  1 = write, 0 = read
//   dm_addr  out  word-aligned byte address
//   dm_wdata out  lane-replicated store data
//   dm_be    out  byte enables
//   dm_ack   in   access completes in the cycle it is high
//   dm_rdata in   read word, valid with dm_ack
interface dmem_access_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// RV32I MEM-stage data-memory sequencer: lane steering, load extension,
// misalignment rejection, one-entry posted store buffer, bus timeout.
// Latency: loads 1 + cycles-to-ack stall cycles; stores into an empty buffer 0.
// Backpressure: combinational stall holds the MEM stage while a load, fence
// or a store behind a pending store cannot complete.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   mem_read/mem_write/fence, funct3, addr, wdata   MEM-stage decode + operands
//   stall               combinational pipeline hold
//   rdata, load_done    extended load result and its one-cycle strobe
//   misaligned          one-cycle pulse, access rejected
//   bus_timeout         one-cycle pulse, access abandoned
//   dm                  memory port (dmem_access_ctrl_if.master)
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  fence,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  load_done,
  output logic                  misaligned,
  output logic                  bus_timeout,
  dmem_access_ctrl_if.master    dm
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [16:0] cnt_inc;
  logic [31:0] rdata_q;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        mis;
  logic        acc_rd, acc_wr, ack_hit, tmo;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign cnt_inc = {1'b0, cnt} + 17'd1;

  // funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 fall into word).
  assign mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
               (funct3[1] && (addr[1:0] != 2'b00));

  always_comb begin
    st_data = wdata;
    st_be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_be   = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_be   = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  // Extraction uses the offset/size latched at acceptance, not the live inputs.
  always_comb begin
    ld_byte = dm.dm_rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte = dm.dm_rdata[15:8];
      2'd2:    ld_byte = dm.dm_rdata[23:16];
      2'd3:    ld_byte = dm.dm_rdata[31:24];
      default: ld_byte = dm.dm_rdata[7:0];
    endcase
    ld_half = ld_off[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (ld_f3[1:0])
      2'b00:   ld_ext = {{24{~ld_f3[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~ld_f3[2] & ld_half[15]}}, ld_half};
      default: ld_ext = dm.dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    ack_hit   = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read) begin
          stall = 1'b1;
          if (mis) state_nxt = ERR;
          else begin
            acc_rd    = 1'b1;
            state_nxt = READ;
          end
        end else if (mem_write) begin
          if (mis) begin
            stall     = 1'b1;
            state_nxt = ERR;
          end else begin
            acc_wr    = 1'b1;
            state_nxt = WRITE;
          end
        end
        // A lone fence in IDLE has nothing to wait for.
      end
      WRITE: begin
        // Posted store: only another memory op has to wait for the buffer.
        stall = mem_read | mem_write | fence;
        if (dm.dm_ack) begin
          ack_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_inc == 17'(TIMEOUT)) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      READ: begin
        stall = 1'b1;
        if (dm.dm_ack) begin
          ack_hit   = 1'b1;
          state_nxt = RDONE;
        end else if (cnt_inc == 17'(TIMEOUT)) begin
          tmo       = 1'b1;
          state_nxt = RDONE;
        end
      end
      RDONE:   state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wdata <= '0;
      dm.dm_be    <= '0;
      bus_timeout <= 1'b0;
      rdata_q     <= '0;
      ld_f3       <= '0;
      ld_off      <= '0;
      cnt         <= '0;
    end else begin
      bus_timeout <= tmo;
      if (acc_wr) begin
        dm.dm_req   <= 1'b1;
        dm.dm_we    <= 1'b1;
        dm.dm_addr  <= {addr[31:2], 2'b00};
        dm.dm_wdata <= st_data;
        dm.dm_be    <= st_be;
      end else if (acc_rd) begin
        dm.dm_req  <= 1'b1;
        dm.dm_we   <= 1'b0;
        dm.dm_addr <= {addr[31:2], 2'b00};
        dm.dm_be   <= 4'b1111;
        ld_f3      <= funct3;
        ld_off     <= addr[1:0];
      end else if (ack_hit || tmo) begin
        dm.dm_req <= 1'b0;
      end
      if (state == READ && ack_hit) rdata_q <= ld_ext;
      else if (state == READ && tmo) rdata_q <= 32'hFFFF_FFFF;
      if (state_nxt != state)                 cnt <= '0;
      else if (state == WRITE || state == READ) cnt <= cnt_inc[15:0];
      else                                    cnt <= '0;
    end
  end

  assign load_done  = (state == RDONE);
  assign misaligned = (state == ERR);
  assign rdata      = load_done ? rdata_q : 32'd0;

endmodule
